if_id_pipe_reg: RTL

//  Next-generation IF/ID pipeline register. Replaces the single-enable latch with a

---
 rtl/if_id_pipe_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshaked 2-entry skid stage carrying PC+4
// and instruction, with flush, NOP injection on bubbles and a saturating stall counter.
module if_id_pipe_reg #(
   parameter int unsigned         PC_W   = 32,
   parameter int unsigned         IR_W   = 32,
   parameter logic [IR_W-1:0]     NOP_IR = '0,
   parameter int unsigned         CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pc4,
   input  logic [IR_W-1:0]  in_ir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc4,
   output logic [IR_W-1:0]  out_ir,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state;
   logic [PC_W-1:0] main_pc4, skid_pc4;
   logic [IR_W-1:0] main_ir,  skid_ir;
   logic            in_fire, out_fire;

   // Handshake signals decode from the state register only, so in_ready never
   // depends combinationally on out_ready.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_pc4   = out_valid ? main_pc4 : '0;
   assign out_ir    = out_valid ? main_ir  : NOP_IR;

   assign in_fire  = in_valid  && in_ready;
   assign out_fire = out_valid && out_ready;

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values; a blocking '=' here would let one update leak into another.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         main_pc4 <= '0;
         main_ir  <= '0;
         skid_pc4 <= '0;
         skid_ir  <= '0;
      end else if (flush) begin
         state    <= EMPTY;
         main_pc4 <= '0;
         main_ir  <= '0;
         skid_pc4 <= '0;
         skid_ir  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_pc4 <= in_pc4;
                  main_ir  <= in_ir;
                  state    <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_pc4 <= in_pc4;
                  main_ir  <= in_ir;
               end else if (in_fire) begin
                  skid_pc4 <= in_pc4;
                  skid_ir  <= in_ir;
                  state    <= FULL;
               end else if (out_fire) begin
                  state    <= EMPTY;
               end
            end
            FULL: begin
               // Skid entry is older than anything IF can present, so it moves up.
               if (out_fire) begin
                  main_pc4 <= skid_pc4;
                  main_ir  <= skid_ir;
                  state    <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Survives flush: it measures decode back-pressure, not pipeline contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
